// File: rtl/rf_wb_arbiter_if.sv
// Writeback-arbiter bus: two writeback requesters, decode issue hook,
// register-file write port and the pending-write scoreboard.
interface rf_wb_arbiter_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    logic              a_valid_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_data_i;
    logic              a_ready_o;

    logic              b_valid_i;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_data_i;
    logic              b_ready_o;

    logic              issue_i;
    logic [ADDR_W-1:0] issue_addr_i;

    logic              rf_wen_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_data_o;
    logic [NREG-1:0]   busy_o;

    // Arbiter side
    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        input  b_valid_i, b_addr_i, b_data_i,
        input  issue_i, issue_addr_i,
        output a_ready_o, b_ready_o,
        output rf_wen_o, rf_waddr_o, rf_data_o, busy_o
    );

    // Requester / environment side
    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        output b_valid_i, b_addr_i, b_data_i,
        output issue_i, issue_addr_i,
        input  a_ready_o, b_ready_o,
        input  rf_wen_o, rf_waddr_o, rf_data_o, busy_o
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: in-order pipeline (A) vs long-latency
// unit (B) with starvation guard for B, one-cycle registered write port and
// a pending-write scoreboard for registers owed by B.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    // Registered state
    logic [CNT_W-1:0]  starve_cnt_q;
    logic [NREG-1:0]   busy_q;
    logic              wen_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] data_q;

    // Next-state values
    logic [CNT_W-1:0]  starve_cnt_d;
    logic [NREG-1:0]   busy_d;
    logic              wen_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] data_d;

    // Arbitration decode
    logic              at_limit_c;
    logic              b_win_c;
    logic              a_grant_c;
    logic              b_grant_c;
    logic              xfer_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_data_c;

    // B wins when alone or once it has been starved long enough; nothing is granted in reset
    always_comb begin
        at_limit_c = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        b_win_c    = bus.b_valid_i && (!bus.a_valid_i || at_limit_c);
        a_grant_c  = !rst_i && bus.a_valid_i && !b_win_c;
        b_grant_c  = !rst_i && b_win_c;
        xfer_c     = a_grant_c || b_grant_c;
        sel_addr_c = b_grant_c ? bus.b_addr_i : bus.a_addr_i;
        sel_data_c = b_grant_c ? bus.b_data_i : bus.a_data_i;
    end

    assign bus.a_ready_o = a_grant_c;
    assign bus.b_ready_o = b_grant_c;

    // Next-state: starvation counter, write-port capture, scoreboard update
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        busy_d       = busy_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        data_d       = data_q;

        // Count only while B is waiting; any B transfer or idle B restarts it
        if (!bus.b_valid_i || b_grant_c) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        // x0 writes are consumed but never reach the register file
        if (xfer_c && (sel_addr_c != '0)) begin
            wen_d   = 1'b1;
            waddr_d = sel_addr_c;
            data_d  = sel_data_c;
        end

        // Clear first, then set, so a new issue to the same register keeps it owned
        if (b_grant_c) begin
            busy_d[bus.b_addr_i] = 1'b0;
        end
        if (bus.issue_i && (bus.issue_addr_i != '0)) begin
            busy_d[bus.issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
            busy_q       <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            data_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
        end
    end

    assign bus.rf_wen_o   = wen_q;
    assign bus.rf_waddr_o = waddr_q;
    assign bus.rf_data_o  = data_q;
    assign bus.busy_o     = busy_q;

    // Structural invariants of the arbiter
    a_one_grant : assert property (@(posedge clk_i) !(bus.a_ready_o && bus.b_ready_o));
    a_x0_free   : assert property (@(posedge clk_i) !bus.busy_o[0]);
    a_cnt_bound : assert property (@(posedge clk_i) starve_cnt_q <= CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table plus hand-built multi-cycle
// sequences; expected register-file writes go through a scoreboard queue.
module tb_rf_wb_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;

    always #5 clk_i = ~clk_i;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        iss;
        logic [4:0]  ia;
        logic        era;
        logic        erb;
    } vec_t;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] data;
    } rfw_t;

    vec_t        tbl[$];
    rfw_t        exp_q[$];
    logic [31:0] exp_busy;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(input logic r,
                                input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                                input logic iss, input logic [4:0] ia,
                                input logic era, input logic erb);
        vec_t v;
        v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv;  v.ba = ba; v.bd = bd;
        v.iss = iss; v.ia = ia; v.era = era; v.erb = erb;
        return v;
    endfunction

    // Apply one cycle of stimulus, check readies, predict and check outputs
    task automatic step(input vec_t v, input string name);
        rfw_t e;
        rfw_t p;
        rst_i            = v.rst;
        bus.a_valid_i    = v.av;
        bus.a_addr_i     = v.aa;
        bus.a_data_i     = v.ad;
        bus.b_valid_i    = v.bv;
        bus.b_addr_i     = v.ba;
        bus.b_data_i     = v.bd;
        bus.issue_i      = v.iss;
        bus.issue_addr_i = v.ia;
        @(negedge clk_i);
        n_vec++;
        if (bus.a_ready_o !== v.era || bus.b_ready_o !== v.erb) begin
            n_err++;
            $display("FAIL %s ready: got a=%b b=%b, want a=%b b=%b",
                     name, bus.a_ready_o, bus.b_ready_o, v.era, v.erb);
        end
        if (v.rst) begin
            p = '{1'b0, 5'd0, 32'd0};
            last_addr = 5'd0;
            last_data = 32'd0;
            exp_busy  = 32'd0;
        end else begin
            if (v.era && v.aa != 5'd0) begin
                p = '{1'b1, v.aa, v.ad};
                last_addr = v.aa;
                last_data = v.ad;
            end else if (v.erb && v.ba != 5'd0) begin
                p = '{1'b1, v.ba, v.bd};
                last_addr = v.ba;
                last_data = v.bd;
            end else begin
                p = '{1'b0, last_addr, last_data};
            end
            if (v.erb) exp_busy[v.ba] = 1'b0;
            if (v.iss && v.ia != 5'd0) exp_busy[v.ia] = 1'b1;
        end
        exp_q.push_back(p);
        @(posedge clk_i);
        #1;
        e = exp_q.pop_front();
        n_vec++;
        if (bus.rf_wen_o !== e.wen || bus.rf_waddr_o !== e.waddr || bus.rf_data_o !== e.data) begin
            n_err++;
            $display("FAIL %s rf write: got wen=%b addr=%0d data=%h, want wen=%b addr=%0d data=%h",
                     name, bus.rf_wen_o, bus.rf_waddr_o, bus.rf_data_o, e.wen, e.waddr, e.data);
        end
        n_vec++;
        if (bus.busy_o !== exp_busy) begin
            n_err++;
            $display("FAIL %s busy: got %h, want %h", name, bus.busy_o, exp_busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        last_addr = 5'd0;
        last_data = 32'd0;
        exp_busy  = 32'd0;

        //                r  av aa     ad            bv ba     bd            iss ia    era  erb
        tbl.push_back(mk(1, 1, 5'd3,  32'h11,       1, 5'd6,  32'h22,       1, 5'd8,  0,   0)); // reset, requests pending
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0,   0));
        tbl.push_back(mk(0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0,  1,   0)); // only A
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0,   0)); // idle -> wen drops
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd10, 32'hB0B0,     0, 5'd0,  0,   1)); // only B
        tbl.push_back(mk(0, 1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,        0, 5'd0,  1,   0)); // A to x0
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd0,  0,   0)); // issue x0 ignored
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9,  0,   0)); // issue 9
        tbl.push_back(mk(0, 1, 5'd9,  32'hA9,       0, 5'd0,  32'h0,        1, 5'd4,  1,   0)); // A to 9 leaves busy
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 5'd0,  0,   1)); // B to 9 clears
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  32'h999,      1, 5'd9,  0,   1)); // set wins
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd20, 32'h2020,     0, 5'd0,  0,   1)); // B to non-busy
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0,  32'h5555,     0, 5'd0,  0,   1)); // B to x0
        tbl.push_back(mk(0, 1, 5'd12, 32'h1,        0, 5'd0,  32'h0,        0, 5'd0,  1,   0)); // ordering: A 12
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd12, 32'h2,        0, 5'd0,  0,   1)); // then B 12
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0,  0,   0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("tbl%0d", i));

        // Sustained contention: four A grants, B on the fifth, then the count restarts
        for (int i = 0; i < 7; i++)
            step(mk(0, 1, 5'(i + 1), 32'(32'h100 + i), 1, 5'd7, 32'(32'h700 + i), 0, 5'd0,
                    i != 4, i == 4), $sformatf("contend%0d", i));
        step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0), "idle_a");

        // B dropping valid clears the count
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 5'd14, 32'(32'h140 + i), 1, 5'd15, 32'h150, 0, 5'd0, 1, 0), "pre_drop");
        step(mk(0, 1, 5'd14, 32'h14F, 0, 5'd15, 32'h150, 0, 5'd0, 1, 0), "b_drop");
        for (int i = 0; i < 5; i++)
            step(mk(0, 1, 5'd16, 32'(32'h160 + i), 1, 5'd17, 32'h170, 0, 5'd0,
                    i != 4, i == 4), $sformatf("post_drop%0d", i));
        step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0), "idle_b");

        // Reset mid-operation with busy 3,4 set and the counter at 3
        step(mk(0, 1, 5'd21, 32'h21, 1, 5'd22, 32'h22, 1, 5'd3, 1, 0), "mid_a");
        step(mk(0, 1, 5'd23, 32'h23, 1, 5'd22, 32'h22, 1, 5'd4, 1, 0), "mid_b");
        step(mk(0, 1, 5'd24, 32'h24, 1, 5'd22, 32'h22, 0, 5'd0, 1, 0), "mid_c");
        step(mk(1, 1, 5'd25, 32'h25, 1, 5'd22, 32'h22, 0, 5'd0, 0, 0), "mid_rst");
        for (int i = 0; i < 5; i++)
            step(mk(0, 1, 5'(26 + i), 32'(32'h260 + i), 1, 5'd22, 32'h22, 0, 5'd0,
                    i != 4, i == 4), $sformatf("after_rst%0d", i));
        step(mk(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0), "idle_c");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
